// File: rtl/sb_config_sequencer.sv
// -----------------------------------------------------------------------------
// sb_config_sequencer
//
// Purpose:
//   Loads configuration words into an array of switch-box tiles. It accepts a
//   stream of (tile address, word) pairs over a valid/ready handshake. For each
//   accepted word it drives the word on config_data and pulses one bit of the
//   one-hot config_en for exactly one cycle. A session ends after
//   EXPECTED_WORDS successful writes.
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begins a load session (sampled in IDLE and DONE only)
//   cfg_valid    in   upstream word valid
//   cfg_ready    out  sequencer can accept a word (high only in ACCEPT)
//   cfg_addr     in   target tile index
//   cfg_word     in   configuration word
//   cfg_parity   in   odd parity over cfg_word (SB_CFG_PARITY_EN builds only)
//   config_data  out  broadcast word to all tiles (registered, holds last word)
//   config_en    out  one-hot write strobe (registered, one cycle per write)
//   busy         out  high in ACCEPT or WRITE
//   done         out  high in DONE
//   err          out  sticky: at least one word was dropped this session
//   word_count   out  words written this session
//
// Build option:
//   SB_CFG_PARITY_EN - when defined, adds cfg_parity. A word whose
//   ^{cfg_word, cfg_parity} is not 1 is dropped, the same way an
//   out-of-range address is dropped.
// -----------------------------------------------------------------------------
module sb_config_sequencer #(
  parameter int NUM_TILES      = 16,
  parameter int ADDR_W         = 4,
  parameter int CFG_W          = 32,
  parameter int EXPECTED_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [CFG_W-1:0]     cfg_word,
`ifdef SB_CFG_PARITY_EN
  input  logic                 cfg_parity,
`endif
  output logic [CFG_W-1:0]     config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           word_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // One extra bit so that NUM_TILES == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] NUM_TILES_W = (ADDR_W + 1)'(NUM_TILES);
  localparam logic [7:0]      EXPECTED_W  = 8'(EXPECTED_WORDS);

  logic [1:0]           state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic                 err_q, err_d;
  logic [NUM_TILES-1:0] en_q, en_d;
  logic [CFG_W-1:0]     data_q, data_d;
  logic                 ready_q, busy_q, done_q;

  logic [NUM_TILES-1:0] addr_onehot;
  logic                 addr_ok;
  logic                 parity_ok;
  logic                 word_ok;

  // The decoder covers only real tiles. Out-of-range addresses decode to all
  // zeros, but those words never reach WRITE in any case.
  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_dec
    assign addr_onehot[gi] = (cfg_addr == ADDR_W'(gi));
  end

  assign addr_ok = ({1'b0, cfg_addr} < NUM_TILES_W);

`ifdef SB_CFG_PARITY_EN
  assign parity_ok = ^{cfg_word, cfg_parity};
`else
  assign parity_ok = 1'b1;
`endif

  assign word_ok = addr_ok & parity_ok;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    en_d    = '0;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ACCEPT;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        // The handshake uses the registered ready. It equals (state == ACCEPT),
        // so a word presented while not ready is never taken.
        if (cfg_valid && ready_q) begin
          if (word_ok) begin
            state_d = S_WRITE;
            en_d    = addr_onehot;
            data_d  = cfg_word;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 8'd1;
        state_d = (count_d == EXPECTED_W) ? S_DONE : S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      en_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      en_q    <= en_d;
      data_q  <= data_d;
      // Status flags are decoded from the next state. This keeps them
      // glitch-free registers that line up with state_q.
      ready_q <= (state_d == S_ACCEPT);
      busy_q  <= (state_d == S_ACCEPT) || (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign cfg_ready   = ready_q;
  assign config_en   = en_q;
  assign config_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_sb_config_sequencer.sv
module tb_sb_config_sequencer;

  localparam int NT  = 12;
  localparam int AW  = 4;
  localparam int CW  = 32;
  localparam int EXP = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_word;
`ifdef SB_CFG_PARITY_EN
  logic          cfg_parity;
`endif
  logic [CW-1:0] config_data;
  logic [NT-1:0] config_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    word_count;

  sb_config_sequencer #(
    .NUM_TILES(NT), .ADDR_W(AW), .CFG_W(CW), .EXPECTED_WORDS(EXP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_word(cfg_word),
`ifdef SB_CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .config_data(config_data), .config_en(config_en),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference model: session-level facts only.
  int          m_count;
  logic        m_err;
  logic [31:0] m_last;
  int          last_hs_cyc;
  int          done_cyc;
  int          first_hs_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [31:0] w);
    return ~(^w);
  endfunction

  function automatic logic accepted(input logic [3:0] a, input logic [31:0] w, input logic p);
    logic ok;
    ok = (int'(a) < NT);
`ifdef SB_CFG_PARITY_EN
    ok = ok && (^{w, p});
`else
    if (p === 1'bx) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Called on a negedge. Returns on a negedge with the DUT ready for the next word.
  task automatic send(input logic [3:0] a, input logic [31:0] w, input logic p, input string tag);
    int  n;
    logic ok;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_word  = w;
`ifdef SB_CFG_PARITY_EN
    cfg_parity = p;
`endif
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk({tag, "_ready_timeout"}, 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b0;
      return;
    end
    ok = accepted(a, w, p);
    @(posedge clk);
    #1;
    cfg_valid   = 1'b0;
    last_hs_cyc = cyc;
    if (ok) begin
      chk({tag, "_en"},    32'(config_en), 32'd1 << a);
      chk({tag, "_data"},  config_data, w);
      chk({tag, "_ready"}, 32'(cfg_ready), 32'd0);
      chk({tag, "_cnt"},   32'(word_count), 32'(m_count));
      @(posedge clk);
      #1;
      m_count++;
      m_last = w;
      chk({tag, "_en_off"}, 32'(config_en), 32'd0);
      chk({tag, "_cnt1"},   32'(word_count), 32'(m_count));
      chk({tag, "_done"},   32'(done), 32'(m_count == EXP));
      chk({tag, "_ready1"}, 32'(cfg_ready), 32'(m_count != EXP));
      chk({tag, "_hold"},   config_data, w);
      if (m_count == EXP) done_cyc = cyc;
    end else begin
      m_err = 1'b1;
      chk({tag, "_drop_en"},  32'(config_en), 32'd0);
      chk({tag, "_drop_err"}, 32'(err), 32'd1);
      chk({tag, "_drop_rdy"}, 32'(cfg_ready), 32'd1);
      chk({tag, "_drop_cnt"}, 32'(word_count), 32'(m_count));
      chk({tag, "_drop_dat"}, config_data, m_last);
    end
    $display("txn %s addr=%0d word=%h %s count=%0d", tag, a, w, ok ? "written" : "dropped", m_count);
    @(negedge clk);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_cnt"},   32'(word_count), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    $display("txn %s session started", tag);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] w;
    logic        p;
    int          guard;

    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_word = '0;
`ifdef SB_CFG_PARITY_EN
    cfg_parity = 1'b0;
`endif
    m_count = 0; m_err = 1'b0; m_last = '0; done_cyc = 0; last_hs_cyc = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_en",    32'(config_en), 32'd0);
    chk("rst_data",  config_data, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_cnt",   32'(word_count), 32'd0);
    reset = 1'b0;

    // IDLE ignores cfg_valid
    cfg_valid = 1'b1; cfg_addr = 4'd3; cfg_word = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_en",    32'(config_en), 32'd0);
      chk("idle_ready", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    chk("idle_cnt", 32'(word_count), 32'd0);

    // First write, then a full back-to-back session
    do_start("s1");
    send(4'd3, 32'hDEAD_BEEF, good_par(32'hDEAD_BEEF), "first");
    first_hs_cyc = last_hs_cyc;
    for (int i = 1; i < EXP; i++) begin
      a = 4'($urandom_range(0, NT - 1));
      w = $urandom;
      send(a, w, good_par(w), "b2b");
    end
    chk("s1_done",   32'(done), 32'd1);
    chk("s1_busy",   32'(busy), 32'd0);
    chk("s1_cnt",    32'(word_count), 32'(EXP));
    // handshake N, +2 per word, exit edge of last WRITE is N + 2*EXP - 1
    chk("s1_cycles", 32'(done_cyc - first_hs_cyc), 32'(2 * EXP - 1));

    // DONE holds and ignores traffic
    cfg_valid = 1'b1; cfg_addr = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("done_en",   32'(config_en), 32'd0);
      chk("done_cnt",  32'(word_count), 32'(EXP));
    end
    cfg_valid = 1'b0;

    // Second session: out-of-range drops, parity, random gaps, ignored start
    do_start("s2");
    send(4'd11, 32'hA5A5_0001, good_par(32'hA5A5_0001), "addr11");
    send(4'd15, 32'hA5A5_0002, good_par(32'hA5A5_0002), "addr15");
    send(4'd13, 32'hA5A5_0003, good_par(32'hA5A5_0003), "addr13");
`ifdef SB_CFG_PARITY_EN
    send(4'd2, 32'h0000_0001, 1'b1, "par_bad");
    send(4'd2, 32'h0000_0001, 1'b0, "par_good");
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_ign_cnt", 32'(word_count), 32'(m_count));
    chk("start_ign_rdy", 32'(cfg_ready), 32'd1);
    chk("start_ign_err", 32'(err), 32'(m_err));
    @(negedge clk);
    guard = 0;
    while (m_count < EXP && guard < 200) begin
      a = 4'($urandom_range(0, 15));
      w = $urandom;
      p = good_par(w);
`ifdef SB_CFG_PARITY_EN
      if ($urandom_range(0, 7) == 0) p = ~p;
`endif
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_en", 32'(config_en), 32'd0);
      end
      send(a, w, p, "rnd");
      guard++;
    end
    chk("s2_complete", 32'(m_count), 32'(EXP));
    chk("s2_done",     32'(done), 32'd1);
    chk("s2_err",      32'(err), 32'(m_err));
    chk("s2_err_set",  32'(err), 32'd1);

    // Asynchronous reset in the middle of a WRITE
    do_start("s3");
    send(4'd1, 32'h0BAD_F00D, good_par(32'h0BAD_F00D), "pre_rst");
    cfg_valid = 1'b1; cfg_addr = 4'd5; cfg_word = 32'h5555_AAAA;
`ifdef SB_CFG_PARITY_EN
    cfg_parity = good_par(32'h5555_AAAA);
`endif
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("wr5_en", 32'(config_en), 32'h20);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_en",    32'(config_en), 32'd0);
    chk("arst_cnt",   32'(word_count), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd0);
    chk("arst_data",  config_data, 32'd0);
    $display("txn async reset during WRITE addr=5");
    @(negedge clk);
    reset = 1'b0;
    m_count = 0; m_err = 1'b0; m_last = '0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    do_start("s4");
    send(4'd5, 32'h5555_AAAA, good_par(32'h5555_AAAA), "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
